// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB register, decode-stage read ports and the
// write-back/register-file block.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // No valid/ready pair: wb_en_in alone qualifies a write in the cycle it is
  // high, the file never back-pressures, and read ports are purely combinational.
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic [DATA_W-1:0] alu_res_in;
  logic [DATA_W-1:0] mem_read_val_in;
  logic [ADDR_W-1:0] dest_in;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [DATA_W-1:0] wb_value;
  logic [ADDR_W-1:0] wb_dest;
  logic              wb_commit;
  logic [31:0]       retire_count;

  modport master (
    output wb_en_in, mem_r_en_in, alu_res_in, mem_read_val_in, dest_in,
    output src1, src2,
    input  reg1, reg2, wb_value, wb_dest, wb_commit, retire_count
  );

  modport slave (
    input  wb_en_in, mem_r_en_in, alu_res_in, mem_read_val_in, dest_in,
    input  src1, src2,
    output reg1, reg2, wb_value, wb_dest, wb_commit, retire_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back value select, 32-entry architectural register file with
// write-first bypass on both read ports, and a retired-write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic          clk,
  input  logic          rst,
  wb_regfile_if.slave   bus
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [31:0]       retire_count_q;
  logic [31:0]       retire_count_d;

  logic [DATA_W-1:0] wb_value;
  logic              wb_commit;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;

  always_comb begin
    wb_value  = bus.mem_r_en_in ? bus.mem_read_val_in : bus.alu_res_in;
    wb_commit = bus.wb_en_in && (bus.dest_in != '0) && !rst;
  end

  // Read ports resolve independently; bypass wins over the stored value so the
  // decode stage sees the instruction retiring in the same cycle.
  always_comb begin
    reg1 = '0;
    if (bus.src1 != '0) begin
      if (wb_commit && (bus.dest_in == bus.src1)) reg1 = wb_value;
      else                                        reg1 = regs_q[bus.src1];
    end
  end

  always_comb begin
    reg2 = '0;
    if (bus.src2 != '0) begin
      if (wb_commit && (bus.dest_in == bus.src2)) reg2 = wb_value;
      else                                        reg2 = regs_q[bus.src2];
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    retire_count_d = retire_count_q;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
      retire_count_d = '0;
    end else begin
      if (wb_commit) regs_d[bus.dest_in] = wb_value;
      // Writes to index 0 still retire an instruction, so they count.
      if (bus.wb_en_in) retire_count_d = retire_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    retire_count_q <= retire_count_d;
  end

  assign bus.wb_value     = wb_value;
  assign bus.wb_dest      = bus.dest_in;
  assign bus.wb_commit    = wb_commit;
  assign bus.reg1         = reg1;
  assign bus.reg2         = reg2;
  assign bus.retire_count = retire_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed, table-driven bench for wb_regfile: per-row stimulus with
// hand-computed combinational outputs and counter value, plus corner sequences.
module tb_wb_regfile;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [31:0] exp_reg1;
    logic [31:0] exp_reg2;
    logic [31:0] exp_wbv;
    logic        exp_commit;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic mr,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] dest, input logic [4:0] s1, input logic [4:0] s2);
    rst                 = r;
    bus.wb_en_in        = we;
    bus.mem_r_en_in     = mr;
    bus.alu_res_in      = alu;
    bus.mem_read_val_in = mem;
    bus.dest_in         = dest;
    bus.src1            = s1;
    bus.src2            = s2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //          rst we mr alu            mem            dst s1 s2  reg1          reg2          wbv           cm cnt
    vecs[0]  = '{1'b1,1'b1,1'b0,32'h0000_1234,32'h0,        5, 5, 5, 32'h0,        32'h0,        32'h0000_1234,1'b0,32'd0};
    vecs[1]  = '{1'b1,1'b1,1'b0,32'h0000_1234,32'h0,        5, 5, 5, 32'h0,        32'h0,        32'h0000_1234,1'b0,32'd0};
    vecs[2]  = '{1'b0,1'b1,1'b0,32'hDEAD_BEEF,32'h55,       3, 5, 3, 32'h0,        32'hDEAD_BEEF,32'hDEAD_BEEF,1'b1,32'd0};
    vecs[3]  = '{1'b0,1'b1,1'b1,32'h77,       32'hCAFE_F00D,4, 3, 4, 32'hDEAD_BEEF,32'hCAFE_F00D,32'hCAFE_F00D,1'b1,32'd1};
    vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        0, 3, 4, 32'hDEAD_BEEF,32'hCAFE_F00D,32'h0,        1'b0,32'd2};
    vecs[5]  = '{1'b0,1'b1,1'b0,32'h11,       32'h0,        7, 0, 6, 32'h0,        32'h0,        32'h11,       1'b1,32'd2};
    vecs[6]  = '{1'b0,1'b0,1'b0,32'h22,       32'h0,        7, 7, 7, 32'h11,       32'h11,       32'h22,       1'b0,32'd3};
    vecs[7]  = '{1'b0,1'b1,1'b0,32'h22,       32'h0,        7, 7, 7, 32'h22,       32'h22,       32'h22,       1'b1,32'd3};
    vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        7, 7, 3, 32'h22,       32'hDEAD_BEEF,32'h0,        1'b0,32'd4};
    vecs[9]  = '{1'b0,1'b1,1'b0,32'hFFFF_FFFF,32'h0,        0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFF,1'b0,32'd4};
    vecs[10] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        0, 0, 7, 32'h0,        32'h22,       32'h0,        1'b0,32'd5};
    vecs[11] = '{1'b0,1'b1,1'b1,32'h1,        32'h99,       3, 3, 4, 32'h99,       32'hCAFE_F00D,32'h99,       1'b1,32'd5};
    vecs[12] = '{1'b0,1'b1,1'b0,32'h1,        32'h0,        9, 9, 9, 32'h1,        32'h1,        32'h1,        1'b1,32'd6};
    vecs[13] = '{1'b1,1'b1,1'b0,32'hABCD,     32'h0,        9, 9, 3, 32'h1,        32'h99,       32'hABCD,     1'b0,32'd7};
    vecs[14] = '{1'b0,1'b1,1'b0,32'h5,        32'h0,        9, 9, 3, 32'h5,        32'h0,        32'h5,        1'b1,32'd0};
    vecs[15] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        0, 9, 4, 32'h5,        32'h0,        32'h0,        1'b0,32'd1};

    // One idle reset edge so the array holds defined contents.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].wb_en, vecs[i].mem_r_en, vecs[i].alu, vecs[i].mem,
            vecs[i].dest, vecs[i].src1, vecs[i].src2);
      #1;
      check("reg1",         i, bus.reg1,         vecs[i].exp_reg1);
      check("reg2",         i, bus.reg2,         vecs[i].exp_reg2);
      check("wb_value",     i, bus.wb_value,     vecs[i].exp_wbv);
      check("wb_commit",    i, {31'd0, bus.wb_commit}, {31'd0, vecs[i].exp_commit});
      check("wb_dest",      i, {27'd0, bus.wb_dest},   {27'd0, vecs[i].dest});
      check("retire_count", i, bus.retire_count, vecs[i].exp_count);
    end

    // Back-to-back writes to one index leave the last value.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'hAAAA_0001, 32'h0, 5'd12, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'hBBBB_0002, 32'h0, 5'd12, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd12);
    #1;
    check("b2b_reg1", 100, bus.reg1, 32'hBBBB_0002);
    check("b2b_count", 100, bus.retire_count, 32'd3);

    // Counter wrap via backdoor preload of the counter flop.
    @(negedge clk);
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    #1;
    check("wrap_preload", 101, bus.retire_count, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check("wrap_zero", 102, bus.retire_count, 32'h0);
    @(negedge clk);
    #1;
    check("wrap_hold", 103, bus.retire_count, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
